encode_8b10b_nlane: RTL and testbench

ENCODE_8B10B_NLANE -- requirements
Module: encode_8b10b_nlane

---
 rtl/aurora_8b10b_pkg.sv | 35 +++
 rtl/encode_8b10b_lane.sv | 104 ++++++++++
 rtl/encode_8b10b_nlane.sv | 95 +++++++++
 tb/tb_encode_8b10b_nlane.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_8b10b_pkg.sv
// Shared 8b/10b definitions: symbol type, lane count limits and the
// control-character set accepted as legal K codes.
package aurora_8b10b_pkg;

    localparam int LANES_MIN = 1;
    localparam int LANES_MAX = 8;

    // 10-bit line symbol, bit 9 = a (sent first) ... bit 0 = j.
    typedef logic [9:0] sym10_t;

    // Legal control characters, byte form HGF_EDCBA.
    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_2 = 8'h5C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_6 = 8'hDC;
    localparam logic [7:0] K28_7 = 8'hFC;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;

    // True when a byte flagged as control is one of the twelve defined K codes.
    function automatic logic is_legal_k(input logic [7:0] b);
        case (b)
            K28_0, K28_1, K28_2, K28_3,
            K28_4, K28_5, K28_6, K28_7,
            K23_7, K27_7, K29_7, K30_7: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/encode_8b10b_lane.sv
// Combinational single-byte 8b/10b encoder (5b/6b + 3b/4b) with running
// disparity in/out. Illegal K codes are encoded with the same equations
// and flagged on kerr.
module encode_8b10b_lane
    import aurora_8b10b_pkg::*;
(
    input  logic [7:0] data,
    input  logic       ctrl,
    input  logic       disp_in,
    output logic [9:0] code,
    output logic       disp_out,
    output logic       kerr
);

    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] six_m;      // abcdei as used with negative disparity
    logic [5:0] six;
    logic       rd6;        // disparity after the 6b sub-block
    logic       use_a7;
    logic [3:0] four_p;     // fghj as used after positive disparity
    logic       four_comp;
    logic [3:0] four;

    assign x = data[4:0];
    assign y = data[7:5];

    // 5b/6b sub-block: table lookup, complemented for positive disparity
    // when the code is unbalanced (and for D.7, whose two forms differ).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // can leave it unassigned and infer a latch.
        six_m = 6'b000000;
        case (x)
            5'd0:  six_m = 6'b100111;
            5'd1:  six_m = 6'b011101;
            5'd2:  six_m = 6'b101101;
            5'd3:  six_m = 6'b110001;
            5'd4:  six_m = 6'b110101;
            5'd5:  six_m = 6'b101001;
            5'd6:  six_m = 6'b011001;
            5'd7:  six_m = 6'b111000;
            5'd8:  six_m = 6'b111001;
            5'd9:  six_m = 6'b100101;
            5'd10: six_m = 6'b010101;
            5'd11: six_m = 6'b110100;
            5'd12: six_m = 6'b001101;
            5'd13: six_m = 6'b101100;
            5'd14: six_m = 6'b011100;
            5'd15: six_m = 6'b010111;
            5'd16: six_m = 6'b011011;
            5'd17: six_m = 6'b100011;
            5'd18: six_m = 6'b010011;
            5'd19: six_m = 6'b110010;
            5'd20: six_m = 6'b001011;
            5'd21: six_m = 6'b101010;
            5'd22: six_m = 6'b011010;
            5'd23: six_m = 6'b111010;
            5'd24: six_m = 6'b110011;
            5'd25: six_m = 6'b100110;
            5'd26: six_m = 6'b010110;
            5'd27: six_m = 6'b110110;
            5'd28: six_m = ctrl ? 6'b001111 : 6'b001110;
            5'd29: six_m = 6'b101110;
            5'd30: six_m = 6'b011110;
            5'd31: six_m = 6'b101011;
            default: six_m = 6'b000000;
        endcase
        if (disp_in && (($countones(six_m) != 3) || (x == 5'd7)))
            six = ~six_m;
        else
            six = six_m;
        rd6 = ($countones(six) != 3) ? ~disp_in : disp_in;
    end

    // 3b/4b sub-block: A7 replaces P7 where P7 would form a run of five,
    // and always for control characters. Control codes complement the
    // balanced forms too, which gives the K28.x comma alignment.
    always_comb begin
        use_a7 = (y == 3'd7) &&
                 (ctrl ||
                  (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                  ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
        four_p = 4'b0000;
        case (y)
            3'd0: four_p = 4'b0100;
            3'd1: four_p = 4'b1001;
            3'd2: four_p = 4'b0101;
            3'd3: four_p = 4'b0011;
            3'd4: four_p = 4'b0010;
            3'd5: four_p = 4'b1010;
            3'd6: four_p = 4'b0110;
            3'd7: four_p = use_a7 ? 4'b1000 : 4'b0001;
            default: four_p = 4'b0000;
        endcase
        four_comp = ctrl || (y == 3'd0) || (y == 3'd3) || (y == 3'd4) || (y == 3'd7);
        four      = (!rd6 && four_comp) ? ~four_p : four_p;
        disp_out  = ($countones(four) != 2) ? ~rd6 : rd6;
    end

    assign code = {six, four};
    assign kerr = ctrl && !is_legal_k(data);

endmodule

// File: rtl/encode_8b10b_nlane.sv
// Multi-lane 8b/10b encoder: G_LANES byte lanes per beat, disparity chained
// lane 0 -> lane G_LANES-1, running disparity held across beats, optional
// single-stage output register with valid/ready handshake.
module encode_8b10b_nlane
    import aurora_8b10b_pkg::*;
#(
    parameter int G_LANES = 4,
    parameter int G_OREG  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [8*G_LANES-1:0]  data_i,
    input  logic [G_LANES-1:0]    ctrl_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  disp_clr_i,
    output logic [10*G_LANES-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [G_LANES-1:0]    kerr_o,
    output logic                  disp_o
);

    if ((G_LANES < LANES_MIN) || (G_LANES > LANES_MAX)) begin : g_bad_lanes
        $error("encode_8b10b_nlane: G_LANES out of range");
    end

    logic                  rd;          // running disparity, 0 = negative
    logic                  accept;
    logic [G_LANES:0]      chain;       // disparity into lane n / out of last lane
    logic [10*G_LANES-1:0] enc_data;
    logic [G_LANES-1:0]    enc_kerr;

    assign accept   = valid_i && ready_o;
    // A disparity clear only takes effect on a beat that is actually taken.
    assign chain[0] = (disp_clr_i && accept) ? 1'b0 : rd;

    for (genvar n = 0; n < G_LANES; n++) begin : g_lane
        encode_8b10b_lane u_lane (
            .data     (data_i[8*n +: 8]),
            .ctrl     (ctrl_i[n]),
            .disp_in  (chain[n]),
            .code     (enc_data[10*n +: 10]),
            .disp_out (chain[n+1]),
            .kerr     (enc_kerr[n])
        );
    end

    // Running disparity advances only when a beat is accepted.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i)
            rd <= 1'b0;
        else if (accept)
            rd <= chain[G_LANES];
    end

    if (G_OREG != 0) begin : g_oreg
        logic [10*G_LANES-1:0] data_q;
        logic [G_LANES-1:0]    kerr_q;
        logic                  disp_q;
        logic                  valid_q;

        // Output stage: load on accept, drop valid once consumed, hold on stall.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                data_q  <= '0;
                kerr_q  <= '0;
                disp_q  <= 1'b0;
                valid_q <= 1'b0;
            end else if (accept) begin
                data_q  <= enc_data;
                kerr_q  <= enc_kerr;
                disp_q  <= chain[G_LANES];
                valid_q <= 1'b1;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
        end

        assign ready_o = !rst_i && (!valid_q || ready_i);
        assign data_o  = data_q;
        assign kerr_o  = kerr_q;
        assign disp_o  = disp_q;
        assign valid_o = valid_q;
    end else begin : g_comb
        assign ready_o = !rst_i && ready_i;
        assign valid_o = !rst_i && valid_i;
        assign data_o  = rst_i ? '0 : enc_data;
        assign kerr_o  = rst_i ? '0 : enc_kerr;
        assign disp_o  = !rst_i && chain[G_LANES];
    end

endmodule

// File: tb/tb_encode_8b10b_nlane.sv
// Scoreboard bench for encode_8b10b_nlane (G_LANES=4, registered output).
module tb_encode_8b10b_nlane;

    localparam int L        = 4;
    localparam int N_RANDOM = 10000;

    logic            clk_i      = 1'b0;
    logic            rst_i      = 1'b1;
    logic [8*L-1:0]  data_i     = '0;
    logic [L-1:0]    ctrl_i     = '0;
    logic            valid_i    = 1'b0;
    logic            disp_clr_i = 1'b0;
    logic            ready_i    = 1'b1;
    logic            ready_o;
    logic [10*L-1:0] data_o;
    logic            valid_o;
    logic [L-1:0]    kerr_o;
    logic            disp_o;

    encode_8b10b_nlane #(.G_LANES(L), .G_OREG(1)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .ctrl_i     (ctrl_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .disp_clr_i (disp_clr_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .kerr_o     (kerr_o),
        .disp_o     (disp_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference tables (standard 8b/10b code tables) -------
    localparam logic [5:0] T6N [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] T6P [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    localparam logic [3:0] T4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                       4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                       4'b0010, 4'b1010, 4'b0110, 4'b0001};
    // K28.y full symbols for negative disparity; positive form is the complement.
    localparam logic [9:0] K28N [8] = '{10'h0F4, 10'h0F9, 10'h0F5, 10'h0F3,
                                        10'h0F2, 10'h0FA, 10'h0F6, 10'h0F8};
    localparam logic [7:0] KLEGAL [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                           8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    function automatic logic ref_legal_k(input logic [7:0] b);
        for (int i = 0; i < 12; i++) if (KLEGAL[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    // Byte-level reference encoder for data and legal control characters.
    function automatic void enc_ref(input logic [7:0] b, input logic k, input logic rd_in,
                                    output logic [9:0] sym, output logic rd_out);
        int         x;
        int         y;
        logic [5:0] s6;
        logic [3:0] s4;
        logic       rd6;
        x = int'(b[4:0]);
        y = int'(b[7:5]);
        if (k) begin
            case (b)
                8'hF7:   sym = 10'h3A8;
                8'hFB:   sym = 10'h368;
                8'hFD:   sym = 10'h2E8;
                8'hFE:   sym = 10'h1E8;
                default: sym = K28N[y];
            endcase
            if (rd_in) sym = ~sym;
        end else begin
            s6 = rd_in ? T6P[x] : T6N[x];
            case ($countones(s6))
                4:       rd6 = 1'b1;
                2:       rd6 = 1'b0;
                default: rd6 = rd_in;
            endcase
            if (y == 7 && ((!rd6 && (x == 17 || x == 18 || x == 20)) ||
                           ( rd6 && (x == 11 || x == 13 || x == 14))))
                s4 = rd6 ? 4'b1000 : 4'b0111;
            else
                s4 = rd6 ? T4P[y] : T4N[y];
            sym = {s6, s4};
        end
        case ($countones(sym))
            6:       rd_out = 1'b1;
            4:       rd_out = 1'b0;
            default: rd_out = rd_in;
        endcase
    endfunction

    // ---------------- scoreboard ----------------------------------------
    typedef struct {
        logic [10*L-1:0] data;
        logic [L-1:0]    kerr;
        logic            disp;
        logic [L-1:0]    lmask;   // lane content not predicted
        logic            dmask;   // disparity not predicted
        logic            resync;  // stream restarts: reset run tracking
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   rdy_mode    = 0;      // 0 = ready high, 1 = random, 2 = ready low
    logic model_rd    = 1'b0;
    logic model_known = 1'b1;
    logic pend_resync = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t model_beat(input logic [8*L-1:0] d, input logic [L-1:0] c,
                                        input logic clr);
        exp_t       e;
        logic       rd;
        logic       known;
        logic [9:0] sym;
        e.data   = '0;
        e.kerr   = '0;
        e.lmask  = '0;
        e.resync = clr || pend_resync;
        pend_resync = 1'b0;
        rd    = clr ? 1'b0 : model_rd;
        known = clr || model_known;
        for (int n = 0; n < L; n++) begin
            if (c[n] && !ref_legal_k(d[8*n +: 8])) begin
                e.kerr[n] = 1'b1;
                known     = 1'b0;
            end
            if (!known) begin
                e.lmask[n] = 1'b1;
            end else begin
                enc_ref(d[8*n +: 8], c[n], rd, sym, rd);
                e.data[10*n +: 10] = sym;
            end
        end
        e.disp      = rd;
        e.dmask     = !known;
        model_rd    = rd;
        model_known = known;
        return e;
    endfunction

    // ---------------- downstream ready driver --------------------------
    always @(posedge clk_i) begin
        #2;
        case (rdy_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = ($urandom_range(0, 3) != 0);
            default: ready_i = 1'b0;
        endcase
    end

    // ---------------- monitor ------------------------------------------
    logic            stall_prev = 1'b0;
    logic [10*L-1:0] snap_data;
    logic [L-1:0]    snap_kerr;
    logic            snap_disp;
    int              run_len    = 0;
    logic            last_bit   = 1'b0;

    always @(negedge clk_i) begin
        exp_t            e;
        logic [10*L-1:0] m;
        logic [9:0]      sym;
        int              max_run;
        int              bad_ones;
        if (rst_i) begin
            stall_prev = 1'b0;
        end else begin
            check("ready_o_rule", ready_o, !valid_o || ready_i);
            if (stall_prev) begin
                check("stall_data_hold", data_o, snap_data);
                check("stall_kerr_hold", kerr_o, snap_kerr);
                check("stall_disp_hold", disp_o, snap_disp);
            end
            stall_prev = valid_o && !ready_i;
            snap_data  = data_o;
            snap_kerr  = kerr_o;
            snap_disp  = disp_o;
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    m = '0;
                    for (int n = 0; n < L; n++) if (e.lmask[n]) m[10*n +: 10] = '1;
                    check("beat_data", data_o & ~m, e.data & ~m);
                    check("beat_kerr", kerr_o, e.kerr);
                    if (!e.dmask) check("beat_disp", disp_o, e.disp);
                    if (e.resync) run_len = 0;
                    max_run  = 0;
                    bad_ones = 0;
                    for (int n = 0; n < L; n++) begin
                        if (e.lmask[n]) begin
                            run_len = 0;
                        end else begin
                            sym = data_o[10*n +: 10];
                            if ($countones(sym) < 4 || $countones(sym) > 6) bad_ones++;
                            for (int b = 9; b >= 0; b--) begin
                                if (run_len > 0 && sym[b] == last_bit) run_len++;
                                else run_len = 1;
                                last_bit = sym[b];
                                if (run_len > max_run) max_run = run_len;
                            end
                        end
                    end
                    check("lanes_with_bad_ones_count", 64'(bad_ones), 64'd0);
                    check("run_over_5", 64'(max_run > 5), 64'd0);
                end
            end
        end
    end

    // ---------------- stimulus -----------------------------------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Present a beat, hold until accepted, push its expectation on acceptance.
    task automatic send_beat(input logic [8*L-1:0] d, input logic [L-1:0] c, input logic clr,
                             input logic use_exp, input logic [10*L-1:0] xd, input logic xdisp);
        exp_t e;
        int   waited;
        logic taken;
        waited     = 0;
        taken      = 1'b0;
        data_i     = d;
        ctrl_i     = c;
        disp_clr_i = clr;
        valid_i    = 1'b1;
        while (!taken && waited < 200) begin
            @(negedge clk_i);
            if (ready_o) taken = 1'b1;
            else waited++;
        end
        if (!taken) begin
            check("accept_timeout", 64'd1, 64'd0);
        end else begin
            e = model_beat(d, c, clr);
            if (use_exp) begin
                e.data = xd;
                e.disp = xdisp;
            end
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        valid_i    = 1'b0;
        disp_clr_i = 1'b0;
    endtask

    task automatic rand_beat(output logic [8*L-1:0] d, output logic [L-1:0] c,
                             output logic clr);
        for (int n = 0; n < L; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                c[n]         = 1'b1;
                d[8*n +: 8]  = KLEGAL[$urandom_range(0, 11)];
            end else begin
                c[n]         = 1'b0;
                d[8*n +: 8]  = 8'($urandom);
            end
        end
        clr = ($urandom_range(0, 63) == 0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || valid_o) && t < 500) begin
            @(posedge clk_i);
            t++;
        end
        #1;
        check("drain_pending_beats", 64'(sb.size()), 64'd0);
    endtask

    localparam logic [8*L-1:0]  B_COMMA = {8'hB5, 8'hB5, 8'hB5, 8'hBC};
    localparam logic [10*L-1:0] X_COMMA = {10'h2AA, 10'h2AA, 10'h2AA, 10'h0FA};
    localparam logic [10*L-1:0] X_K285P = {10'h0FA, 10'h305, 10'h0FA, 10'h305};
    localparam logic [10*L-1:0] X_D00   = {10'h274, 10'h274, 10'h274, 10'h274};

    initial begin
        logic [8*L-1:0]  d;
        logic [L-1:0]    c;
        logic            clr;
        logic [10*L-1:0] hold;

        // reset state
        repeat (2) @(negedge clk_i);
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_data_o", data_o, '0);
        check("rst_kerr_o", kerr_o, '0);
        check("rst_disp_o", disp_o, 1'b0);
        check("rst_ready_o", ready_o, 1'b0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle(1);

        // directed beats, back to back
        send_beat(B_COMMA, 4'b0001, 1'b0, 1'b1, X_COMMA, 1'b1);
        @(negedge clk_i);
        check("latency_valid_o", valid_o, 1'b1);
        @(posedge clk_i);
        #1;
        send_beat({4{8'hBC}}, 4'b1111, 1'b0, 1'b1, X_K285P, 1'b1);
        send_beat('0, 4'b0000, 1'b1, 1'b1, X_D00, 1'b0);   // clear after RD=1
        send_beat('0, 4'b0000, 1'b0, 1'b1, X_D00, 1'b0);   // RD negative, unchanged
        send_beat('0, 4'b0100, 1'b0, 1'b0, '0, 1'b0);      // K0.0 on lane 2
        send_beat(B_COMMA, 4'b0001, 1'b1, 1'b1, X_COMMA, 1'b1);
        idle(3);

        // stall: one beat held in the output stage, the next held at the input
        rdy_mode = 2;
        idle(1);
        rand_beat(d, c, clr);
        send_beat(d, c, clr, 1'b0, '0, 1'b0);
        rand_beat(d, c, clr);
        fork
            send_beat(d, c, clr, 1'b0, '0, 1'b0);
            begin
                @(negedge clk_i);
                hold = data_o;
                check("stall_ready_o", ready_o, 1'b0);
                repeat (4) begin
                    @(negedge clk_i);
                    check("stall_ready_o", ready_o, 1'b0);
                    check("stall_data_o", data_o, hold);
                end
                rdy_mode = 0;
            end
        join

        // randomized traffic with random backpressure and idle gaps
        rdy_mode = 1;
        for (int i = 0; i < N_RANDOM; i++) begin
            rand_beat(d, c, clr);
            send_beat(d, c, clr, 1'b0, '0, 1'b0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rdy_mode = 0;
        drain();

        // reset with a beat in flight: beat discarded, RD restarts negative
        rdy_mode = 2;
        idle(1);
        send_beat({4{8'hBC}}, 4'b1111, 1'b0, 1'b0, '0, 1'b0);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("midrst_valid_o", valid_o, 1'b0);
        check("midrst_data_o", data_o, '0);
        check("midrst_ready_o", ready_o, 1'b0);
        sb.delete();
        model_rd    = 1'b0;
        model_known = 1'b1;
        pend_resync = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i    = 1'b0;
        rdy_mode = 0;
        idle(1);
        send_beat(B_COMMA, 4'b0001, 1'b0, 1'b1, X_COMMA, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
